// File: rtl/cpu_trace_parser_pkg.sv
// Shared encodings for the CPU trace parser: FSM states, ASCII tokens and record types.
package cpu_trace_parser_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        StIdle,
        StTime,
        StPc,
        StSp1,
        StGrf,
        StAddr,
        StSp2,
        StLt,
        StSp3,
        StData,
        StDoneR,
        StDoneM,
        StErr
    } state_e;

    localparam logic [7:0] CH_CARET  = 8'h5e;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3a;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2a;
    localparam logic [7:0] CH_LT     = 8'h3c;
    localparam logic [7:0] CH_EQ     = 8'h3d;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SP     = 8'h20;

    localparam logic [1:0] FT_NONE = 2'd0;
    localparam logic [1:0] FT_REG  = 2'd1;
    localparam logic [1:0] FT_MEM  = 2'd2;

endpackage

// File: rtl/cpu_trace_parser_char_class.sv
// Combinational classifier for one trace character: decimal, lowercase hex, space, nibble value.
module cpu_trace_parser_char_class
    import cpu_trace_parser_pkg::*;
(
    input  logic [7:0] char,
    output logic       is_dec,
    output logic       is_hex,
    output logic       is_sp,
    output logic [3:0] nibble
);

    always_comb begin
        is_dec = (char >= 8'h30) && (char <= 8'h39);
        is_hex = is_dec || ((char >= 8'h61) && (char <= 8'h66));
        is_sp  = (char == CH_SP);
        nibble = 4'h0;
        if (is_dec) begin
            nibble = char[3:0];
        end else if (is_hex) begin
            // 'a'..'f' have low nibbles 1..6
            nibble = char[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/cpu_trace_parser.sv
// Streaming parser for CPU trace records; extracts fields, flags semantic errors, counts records.
module cpu_trace_parser
    import cpu_trace_parser_pkg::*;
#(
    parameter int unsigned              TIME_DIGITS  = 4,
    parameter int unsigned              GRF_DIGITS   = 4,
    parameter int unsigned              HEX_DIGITS   = 8,
    parameter int unsigned              TIME_STEP_LG = 1,
    parameter logic [4*HEX_DIGITS-1:0]  PC_MIN       = 32'h00003000,
    parameter logic [4*HEX_DIGITS-1:0]  PC_MAX       = 32'h00004fff,
    parameter logic [4*HEX_DIGITS-1:0]  ADDR_MAX     = 32'h00002fff,
    parameter int unsigned              CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               char,
    output logic [1:0]               format_type,
    output logic [3:0]               error_code,
    output logic [4*TIME_DIGITS-1:0] f_time,
    output logic [4*HEX_DIGITS-1:0]  f_pc,
    output logic [4*HEX_DIGITS-1:0]  f_dest,
    output logic [4*HEX_DIGITS-1:0]  f_data,
    output logic [CNT_W-1:0]         rec_count
);

    localparam int unsigned TW = 4 * TIME_DIGITS;
    localparam int unsigned GW = 4 * GRF_DIGITS;
    localparam int unsigned HW = 4 * HEX_DIGITS;
    localparam int unsigned MAX_TG = (TIME_DIGITS > GRF_DIGITS) ? TIME_DIGITS : GRF_DIGITS;
    localparam int unsigned MAX_DIGITS = (MAX_TG > HEX_DIGITS) ? MAX_TG : HEX_DIGITS;
    localparam int unsigned DW = $clog2(MAX_DIGITS + 1);

    localparam logic [DW-1:0] TIME_N = DW'(TIME_DIGITS);
    localparam logic [DW-1:0] GRF_N  = DW'(GRF_DIGITS);
    localparam logic [DW-1:0] HEX_N  = DW'(HEX_DIGITS);
    localparam logic [TW-1:0] TEN_T  = TW'(10);
    localparam logic [GW-1:0] TEN_G  = GW'(10);
    localparam logic [TW-1:0] TIME_MASK = TW'((64'd1 << TIME_STEP_LG) - 64'd1);

    logic       is_dec, is_hex, is_sp;
    logic [3:0] nibble;

    cpu_trace_parser_char_class u_char_class (
        .char   (char),
        .is_dec (is_dec),
        .is_hex (is_hex),
        .is_sp  (is_sp),
        .nibble (nibble)
    );

    state_e            state_q, state_d;
    logic [DW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [TW-1:0]     time_q, time_d;
    logic [HW-1:0]     pc_q, pc_d;
    logic [GW-1:0]     grf_q, grf_d;
    logic [HW-1:0]     addr_q, addr_d;
    logic [HW-1:0]     data_q, data_d;
    logic              is_mem_q, is_mem_d;
    logic [1:0]        format_type_q, format_type_d;
    logic [3:0]        error_code_q, error_code_d;
    logic [TW-1:0]     f_time_q, f_time_d;
    logic [HW-1:0]     f_pc_q, f_pc_d;
    logic [HW-1:0]     f_dest_q, f_dest_d;
    logic [HW-1:0]     f_data_q, f_data_d;
    logic [CNT_W-1:0]  rec_count_q, rec_count_d;

    logic time_bad, pc_bad, addr_bad, grf_bad;

    assign cnt_inc  = cnt_q + 1'b1;
    assign time_bad = (time_q & TIME_MASK) != '0;
    assign pc_bad   = (pc_q < PC_MIN) || (pc_q > PC_MAX) || (pc_q[1:0] != 2'b00);
    assign addr_bad = (addr_q > ADDR_MAX) || (addr_q[1:0] != 2'b00);
    assign grf_bad  = grf_q > GW'(31);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        time_d        = time_q;
        pc_d          = pc_q;
        grf_d         = grf_q;
        addr_d        = addr_q;
        data_d        = data_q;
        is_mem_d      = is_mem_q;
        format_type_d = FT_NONE;
        error_code_d  = 4'b0000;
        f_time_d      = f_time_q;
        f_pc_d        = f_pc_q;
        f_dest_d      = f_dest_q;
        f_data_d      = f_data_q;
        rec_count_d   = rec_count_q;

        if (char == CH_CARET) begin
            // A caret always starts a fresh record, whatever came before.
            state_d  = StTime;
            cnt_d    = '0;
            time_d   = '0;
            pc_d     = '0;
            grf_d    = '0;
            addr_d   = '0;
            data_d   = '0;
            is_mem_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StErr: state_d = state_q;
                StDoneR, StDoneM: state_d = StIdle;
                StTime: begin
                    if (is_dec && (cnt_q < TIME_N)) begin
                        time_d = time_q * TEN_T + TW'(nibble);
                        cnt_d  = cnt_inc;
                    end else if ((char == CH_AT) && (cnt_q != '0)) begin
                        state_d = StPc;
                        cnt_d   = '0;
                    end else begin
                        state_d = StErr;
                    end
                end
                StPc: begin
                    if (is_hex && (cnt_q < HEX_N)) begin
                        pc_d  = {pc_q[HW-5:0], nibble};
                        cnt_d = cnt_inc;
                    end else if ((char == CH_COLON) && (cnt_q == HEX_N)) begin
                        state_d = StSp1;
                        cnt_d   = '0;
                    end else begin
                        state_d = StErr;
                    end
                end
                StSp1: begin
                    if (char == CH_DOLLAR) begin
                        state_d  = StGrf;
                        is_mem_d = 1'b0;
                    end else if (char == CH_STAR) begin
                        state_d  = StAddr;
                        is_mem_d = 1'b1;
                    end else if (!is_sp) begin
                        state_d = StErr;
                    end
                end
                StGrf: begin
                    if (is_dec && (cnt_q < GRF_N)) begin
                        grf_d = grf_q * TEN_G + GW'(nibble);
                        cnt_d = cnt_inc;
                    end else if (is_sp && (cnt_q != '0)) begin
                        state_d = StSp2;
                    end else if ((char == CH_LT) && (cnt_q != '0)) begin
                        state_d = StLt;
                    end else begin
                        state_d = StErr;
                    end
                end
                StAddr: begin
                    if (is_hex && (cnt_q < HEX_N)) begin
                        addr_d = {addr_q[HW-5:0], nibble};
                        cnt_d  = cnt_inc;
                    end else if (is_sp && (cnt_q == HEX_N)) begin
                        state_d = StSp2;
                    end else if ((char == CH_LT) && (cnt_q == HEX_N)) begin
                        state_d = StLt;
                    end else begin
                        state_d = StErr;
                    end
                end
                StSp2: begin
                    if (char == CH_LT) begin
                        state_d = StLt;
                    end else if (!is_sp) begin
                        state_d = StErr;
                    end
                end
                StLt: state_d = (char == CH_EQ) ? StSp3 : StErr;
                StSp3: begin
                    if (is_hex) begin
                        state_d = StData;
                        data_d  = HW'(nibble);
                        cnt_d   = DW'(1);
                    end else if (!is_sp) begin
                        state_d = StErr;
                    end
                end
                StData: begin
                    if (is_hex && (cnt_q < HEX_N)) begin
                        data_d = {data_q[HW-5:0], nibble};
                        cnt_d  = cnt_inc;
                    end else if ((char == CH_HASH) && (cnt_q == HEX_N)) begin
                        state_d       = is_mem_q ? StDoneM : StDoneR;
                        format_type_d = is_mem_q ? FT_MEM : FT_REG;
                        error_code_d  = {grf_bad && !is_mem_q, addr_bad && is_mem_q,
                                         pc_bad, time_bad};
                        f_time_d      = time_q;
                        f_pc_d        = pc_q;
                        f_dest_d      = is_mem_q ? addr_q : HW'(grf_q);
                        f_data_d      = data_q;
                        if (rec_count_q != '1) begin
                            rec_count_d = rec_count_q + 1'b1;
                        end
                    end else begin
                        state_d = StErr;
                    end
                end
                default: state_d = StErr;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            time_q        <= '0;
            pc_q          <= '0;
            grf_q         <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            is_mem_q      <= 1'b0;
            format_type_q <= FT_NONE;
            error_code_q  <= 4'b0000;
            f_time_q      <= '0;
            f_pc_q        <= '0;
            f_dest_q      <= '0;
            f_data_q      <= '0;
            rec_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            time_q        <= time_d;
            pc_q          <= pc_d;
            grf_q         <= grf_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            is_mem_q      <= is_mem_d;
            format_type_q <= format_type_d;
            error_code_q  <= error_code_d;
            f_time_q      <= f_time_d;
            f_pc_q        <= f_pc_d;
            f_dest_q      <= f_dest_d;
            f_data_q      <= f_data_d;
            rec_count_q   <= rec_count_d;
        end
    end

    assign format_type = format_type_q;
    assign error_code  = error_code_q;
    assign f_time      = f_time_q;
    assign f_pc        = f_pc_q;
    assign f_dest      = f_dest_q;
    assign f_data      = f_data_q;
    assign rec_count   = rec_count_q;

endmodule

// File: tb/tb_cpu_trace_parser.sv
// Scoreboard bench for cpu_trace_parser: records queue expected pulses, a monitor pops and checks.
module tb_cpu_trace_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  char = 8'h00;
    logic [1:0]  format_type;
    logic [3:0]  error_code;
    logic [15:0] f_time;
    logic [31:0] f_pc, f_dest, f_data;
    logic [15:0] rec_count;

    typedef struct {
        logic [1:0]  ft;
        logic [3:0]  ec;
        logic [15:0] t;
        logic [31:0] pc;
        logic [31:0] dest;
        logic [31:0] data;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   exp_count = 0;

    cpu_trace_parser u_dut (
        .clk         (clk),
        .reset       (reset),
        .char        (char),
        .format_type (format_type),
        .error_code  (error_code),
        .f_time      (f_time),
        .f_pc        (f_pc),
        .f_dest      (f_dest),
        .f_data      (f_data),
        .rec_count   (rec_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(posedge clk);
            #1 char = s[i];
        end
    endtask

    // Drives a well-formed record and queues the pulse it must produce one cycle after '#'.
    task automatic send_rec(input string s, input logic [1:0] ft, input logic [3:0] ec,
                            input logic [15:0] t, input logic [31:0] pc,
                            input logic [31:0] dest, input logic [31:0] data);
        exp_t e;
        for (int i = 0; i < s.len(); i++) begin
            @(posedge clk);
            #1 char = s[i];
        end
        exp_count++;
        e.ft   = ft;
        e.ec   = ec;
        e.t    = t;
        e.pc   = pc;
        e.dest = dest;
        e.data = data;
        e.cnt  = 16'(exp_count);
        e.cyc  = cyc + 1;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 char = 8'h00;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                check_eq("pulse_missing", 64'(cyc), 64'(sb_q[0].cyc));
                void'(sb_q.pop_front());
            end
            if (format_type != 2'd0) begin
                if (sb_q.size() == 0) begin
                    check_eq("pulse_spurious", 64'(format_type), 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_eq("pulse_cyc", 64'(cyc), 64'(mon_e.cyc));
                    check_eq("format_type", 64'(format_type), 64'(mon_e.ft));
                    check_eq("error_code", 64'(error_code), 64'(mon_e.ec));
                    check_eq("f_time", 64'(f_time), 64'(mon_e.t));
                    check_eq("f_pc", 64'(f_pc), 64'(mon_e.pc));
                    check_eq("f_dest", 64'(f_dest), 64'(mon_e.dest));
                    check_eq("f_data", 64'(f_data), 64'(mon_e.data));
                    check_eq("rec_count", 64'(rec_count), 64'(mon_e.cnt));
                end
            end else begin
                check_eq("ec_idle", 64'(error_code), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ft", 64'(format_type), 64'd0);
        check_eq("rst_ec", 64'(error_code), 64'd0);
        check_eq("rst_time", 64'(f_time), 64'd0);
        check_eq("rst_pc", 64'(f_pc), 64'd0);
        check_eq("rst_dest", 64'(f_dest), 64'd0);
        check_eq("rst_data", 64'(f_data), 64'd0);
        check_eq("rst_count", 64'(rec_count), 64'd0);
        reset = 1'b0;

        send_rec("^10@00003010: $31 <= 12345678#", 2'd1, 4'b0000, 16'd10, 32'h3010, 32'd31,
                 32'h12345678);
        idle(3);
        send_rec("^242@0000300c: *00000088 <= ffffb520#", 2'd2, 4'b0000, 16'd242, 32'h300c,
                 32'h88, 32'hffffb520);
        idle(2);
        send_rec("^241@00003002: *00003000 <=  00000000#", 2'd2, 4'b0111, 16'd241, 32'h3002,
                 32'h3000, 32'h0);
        idle(2);

        send_str("^2@0003010: $1<=00000000#");
        send_str("^2@00003010: $1 <= 0000000B#");
        send_str("^12345@00003010:$1<=00000000#");
        idle(3);
        check_eq("malformed_count", 64'(rec_count), 64'd3);
        check_eq("malformed_hold", 64'(f_time), 64'd241);

        send_str("^2@0000300");
        send_rec("^4@00003000:$32<=00000001#", 2'd1, 4'b1000, 16'd4, 32'h3000, 32'd32, 32'h1);
        idle(2);

        send_rec("^6@00003004: $2 <= 0000000a#", 2'd1, 4'b0000, 16'd6, 32'h3004, 32'd2,
                 32'ha);
        send_rec("^8@00003008: *00000004 <= 000000ff#", 2'd2, 4'b0000, 16'd8, 32'h3008,
                 32'h4, 32'hff);
        send_str("x##");
        idle(3);
        check_eq("stray_count", 64'(rec_count), 64'd6);

        send_str("^10@00003010: $1 <= 1234");
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check_eq("mid_rst_ft", 64'(format_type), 64'd0);
        check_eq("mid_rst_time", 64'(f_time), 64'd0);
        check_eq("mid_rst_pc", 64'(f_pc), 64'd0);
        check_eq("mid_rst_dest", 64'(f_dest), 64'd0);
        check_eq("mid_rst_data", 64'(f_data), 64'd0);
        check_eq("mid_rst_count", 64'(rec_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_count = 0;
        send_str("5678#");
        idle(3);
        check_eq("post_rst_count", 64'(rec_count), 64'd0);
        send_rec("^2@00004ffc: *00002ffc <= deadbeef#", 2'd2, 4'b0000, 16'd2, 32'h4ffc,
                 32'h2ffc, 32'hdeadbeef);
        idle(2);
        send_rec("^2@00002ffc: $0 <= 00000000#", 2'd1, 4'b0010, 16'd2, 32'h2ffc, 32'd0,
                 32'h0);
        idle(4);
        check_eq("sb_left", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
